// File: rtl/game_pkg.sv
// Shared definitions for the match/round sequencer and the gameplay controllers:
// phase, stunmode and winner encodings plus small helpers.
package game_pkg;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_COUNTDOWN  = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_ROUND_END  = 3'd3,
        PH_MATCH_OVER = 3'd4
    } phase_e;

    localparam logic [1:0] STUN_NONE  = 2'b00;
    localparam logic [1:0] STUN_HIT   = 2'b01;
    localparam logic [1:0] STUN_BLOCK = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        GC_IDLE    = 3'd0,
        GC_MOVE    = 3'd1,
        GC_ATTACK  = 3'd2,
        GC_BLOCK   = 3'd3,
        GC_STUNNED = 3'd4
    } gc_state_e;

    localparam int TICK_W = 8;

    function automatic logic [2:0] sat_dec3(input logic [2:0] v);
        return (v == 3'd0) ? v : v - 3'd1;
    endfunction

    // Strictly larger count wins; a tie is a draw.
    function automatic logic [1:0] leader(input logic [2:0] a, input logic [2:0] b);
        if (a > b) return WIN_P1;
        if (b > a) return WIN_P2;
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/player_vitals.sv
// Per-player health/shield bookkeeping: stunmode edge detection, saturating
// damage while enabled, and reload to the starting values.
module player_vitals
    import game_pkg::*;
#(
    parameter logic [2:0] INIT_HEALTH = 3'd3,
    parameter logic [2:0] INIT_SHIELD = 3'd3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [1:0] stunmode_i,
    output logic [2:0] health_o,
    output logic [2:0] shield_o
);

    logic [1:0] prev_q;
    logic [2:0] health_q, health_d;
    logic [2:0] shield_q, shield_d;
    logic       hit_edge, block_edge;

    // Only a change out of "none" counts, so a held code deals damage once.
    assign hit_edge   = (prev_q == STUN_NONE) && (stunmode_i == STUN_HIT);
    assign block_edge = (prev_q == STUN_NONE) && (stunmode_i == STUN_BLOCK);

    always_comb begin
        health_d = health_q;
        shield_d = shield_q;
        if (load_i) begin
            health_d = INIT_HEALTH;
            shield_d = INIT_SHIELD;
        end else if (en_i) begin
            if (hit_edge)   health_d = sat_dec3(health_q);
            if (block_edge) shield_d = sat_dec3(shield_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q   <= STUN_NONE;
            health_q <= INIT_HEALTH;
            shield_q <= INIT_SHIELD;
        end else begin
            prev_q   <= stunmode_i;
            health_q <= health_d;
            shield_q <= shield_d;
        end
    end

    assign health_o = health_q;
    assign shield_o = shield_q;

endmodule

// File: rtl/match_round_controller.sv
// Match/round sequencer: phase FSM, countdown/hold/prescaler counters, round
// timer and win tally, with one player_vitals block per player.
module match_round_controller
    import game_pkg::*;
#(
    parameter int unsigned FRAME_RATE       = 60,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned ROUND_SECONDS    = 99,
    parameter int unsigned END_HOLD_FRAMES  = 120,
    parameter int unsigned INIT_HEALTH      = 3,
    parameter int unsigned INIT_SHIELD      = 3,
    parameter int unsigned WINS_TO_MATCH    = 2,
    parameter int unsigned MAX_ROUNDS       = 5
) (
    input  logic       logic_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [1:0] p1_stunmode,
    input  logic [1:0] p2_stunmode,
    output logic [2:0] health1,
    output logic [2:0] health2,
    output logic [2:0] shield1,
    output logic [2:0] shield2,
    output logic [2:0] phase,
    output logic       players_enable,
    output logic       player_reset,
    output logic [6:0] round_time,
    output logic [2:0] round_num,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic [1:0] winner
);

    localparam logic [TICK_W-1:0] CD_LAST = TICK_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [TICK_W-1:0] EH_LAST = TICK_W'(END_HOLD_FRAMES - 1);
    localparam logic [TICK_W-1:0] FR_LAST = TICK_W'(FRAME_RATE - 1);
    localparam logic [6:0]        RT_INIT = 7'(ROUND_SECONDS);
    localparam logic [1:0]        WINS_T  = 2'(WINS_TO_MATCH);
    localparam logic [2:0]        RN_MAX  = 3'(MAX_ROUNDS);

    phase_e            phase_q;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] presc_q;
    logic [6:0]        rtime_q;
    logic [2:0]        rnum_q;
    logic [1:0]        wins1_q, wins2_q, winner_q;
    logic              pen_q, prst_q, start_prev_q;

    logic start_edge, new_match, round_over, hold_done, match_done, next_round;
    logic reload, vitals_en;

    assign start_edge = start_btn && !start_prev_q;
    assign new_match  = start_edge && ((phase_q == PH_IDLE) || (phase_q == PH_MATCH_OVER));
    assign round_over = (phase_q == PH_FIGHT) &&
                        ((health1 == 3'd0) || (health2 == 3'd0) || (rtime_q == 7'd0));
    assign hold_done  = (phase_q == PH_ROUND_END) && (tick_q == EH_LAST);
    assign match_done = (wins1_q == WINS_T) || (wins2_q == WINS_T) || (rnum_q == RN_MAX);
    assign next_round = hold_done && !match_done;
    assign reload     = new_match || next_round;
    // Damage freezes on the tick the round is decided.
    assign vitals_en  = (phase_q == PH_FIGHT) && !round_over;

    player_vitals #(
        .INIT_HEALTH(3'(INIT_HEALTH)),
        .INIT_SHIELD(3'(INIT_SHIELD))
    ) u_p1 (
        .clk_i      (logic_clk),
        .rst_i      (reset),
        .load_i     (reload),
        .en_i       (vitals_en),
        .stunmode_i (p1_stunmode),
        .health_o   (health1),
        .shield_o   (shield1)
    );

    player_vitals #(
        .INIT_HEALTH(3'(INIT_HEALTH)),
        .INIT_SHIELD(3'(INIT_SHIELD))
    ) u_p2 (
        .clk_i      (logic_clk),
        .rst_i      (reset),
        .load_i     (reload),
        .en_i       (vitals_en),
        .stunmode_i (p2_stunmode),
        .health_o   (health2),
        .shield_o   (shield2)
    );

    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            phase_q      <= PH_IDLE;
            tick_q       <= '0;
            presc_q      <= '0;
            rtime_q      <= RT_INIT;
            rnum_q       <= 3'd0;
            wins1_q      <= 2'd0;
            wins2_q      <= 2'd0;
            winner_q     <= WIN_NONE;
            pen_q        <= 1'b0;
            prst_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_prev_q <= start_btn;
            prst_q       <= reload;
            case (phase_q)
                PH_IDLE, PH_MATCH_OVER: begin
                    if (new_match) begin
                        phase_q  <= PH_COUNTDOWN;
                        tick_q   <= '0;
                        wins1_q  <= 2'd0;
                        wins2_q  <= 2'd0;
                        winner_q <= WIN_NONE;
                        rnum_q   <= 3'd1;
                    end
                end
                PH_COUNTDOWN: begin
                    if (tick_q == CD_LAST) begin
                        phase_q <= PH_FIGHT;
                        tick_q  <= '0;
                        presc_q <= '0;
                        rtime_q <= RT_INIT;
                        pen_q   <= 1'b1;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                PH_FIGHT: begin
                    if (round_over) begin
                        phase_q  <= PH_ROUND_END;
                        tick_q   <= '0;
                        pen_q    <= 1'b0;
                        winner_q <= leader(health1, health2);
                        if (health1 > health2) wins1_q <= wins1_q + 2'd1;
                        if (health2 > health1) wins2_q <= wins2_q + 2'd1;
                    end else if (presc_q == FR_LAST) begin
                        presc_q <= '0;
                        rtime_q <= (rtime_q == 7'd0) ? rtime_q : rtime_q - 7'd1;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                PH_ROUND_END: begin
                    if (hold_done) begin
                        tick_q <= '0;
                        if (match_done) begin
                            phase_q  <= PH_MATCH_OVER;
                            winner_q <= leader({1'b0, wins1_q}, {1'b0, wins2_q});
                        end else begin
                            phase_q <= PH_COUNTDOWN;
                            rnum_q  <= rnum_q + 3'd1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    assign phase          = phase_q;
    assign players_enable = pen_q;
    assign player_reset   = prst_q;
    assign round_time     = rtime_q;
    assign round_num      = rnum_q;
    assign wins1          = wins1_q;
    assign wins2          = wins2_q;
    assign winner         = winner_q;

endmodule
